// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// Module  : sprite_pkg
// Purpose : Shared attribute field positions, scan state encoding and height decode.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package sprite_pkg;

  // Word0 fields
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 15;
  localparam int X_LSB    = 16;
  localparam int X_MSB    = 25;

  // Word1 fields
  localparam int Y_LSB    = 0;
  localparam int Y_MSB    = 9;
  localparam int FLIP_BIT = 17;
  localparam int Z_LSB    = 18;
  localparam int Z_MSB    = 19;
  localparam int SIZE_LSB = 22;
  localparam int SIZE_MSB = 23;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_W0   = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [6:0] height_decode(input logic [1:0] code);
    height_decode = 7'(8 << code);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_hit_check.sv
// ---------------------------------------------------------------------------
// Module  : sprite_hit_check
// Purpose : Vertical hit test and row select for one sprite against a scanline.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sprite_hit_check
  import sprite_pkg::*;
(
  input  logic [31:0] i_word1,
  input  logic [9:0]  i_line,
  output logic        o_hit,
  output logic [5:0]  o_row
);

  logic [9:0] w_dy;
  logic [6:0] w_height;
  logic [6:0] w_row_full;
  logic       w_unused;

  // Modulo-1024 subtraction lets sprites straddle the bottom/top wrap.
  assign w_dy       = i_line - i_word1[Y_MSB:Y_LSB];
  assign w_height   = height_decode(i_word1[SIZE_MSB:SIZE_LSB]);
  assign o_hit      = (i_word1[Z_MSB:Z_LSB] != 2'b00) && (w_dy < {3'b000, w_height});
  assign w_row_full = i_word1[FLIP_BIT] ? (w_height - 7'd1 - w_dy[6:0]) : w_dy[6:0];
  assign o_row      = w_row_full[5:0];

  assign w_unused = ^{i_word1[31:24], i_word1[21:20], i_word1[16:10], w_row_full[6]};

endmodule

`default_nettype wire

// File: rtl/sprite_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : sprite_scan_ctrl
// Purpose : Per-line sprite attribute scanner feeding the renderer by valid/ready.
//           Optional statistics outputs enabled by SPRITE_SCAN_STATS_EN.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sprite_scan_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = 128,
  parameter int MAX_PER_LINE = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_idx_i,
  input  logic        sprites_en_i,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [6:0]  out_idx_o,
  output logic [63:0] out_attr_o,
  output logic [5:0]  out_row_o,
  output logic        busy_o,
  output logic        done_o
`ifdef SPRITE_SCAN_STATS_EN
  ,
  output logic [6:0]  hit_count_o,
  output logic        overflow_o
`endif
);

  localparam logic [6:0] c_last_idx = 7'(NUM_SPRITES - 1);
  localparam logic [6:0] c_hit_cap  = 7'(MAX_PER_LINE);

  state_t      r_state;
  logic [9:0]  r_line;
  logic [6:0]  r_idx;
  logic [6:0]  r_hits;
  logic [63:0] r_attr;
  logic [5:0]  r_row;
  logic        r_valid;
  logic        r_done;

  logic        w_hit;
  logic [5:0]  w_row;
  logic [6:0]  w_next_idx;
  logic [6:0]  w_hits_inc;
  logic        w_last;
  logic        w_cap;
  logic        w_handshake;
  logic        w_to_done;

  sprite_hit_check u_hit_check (
    .i_word1 (rd_data_i),
    .i_line  (r_line),
    .o_hit   (w_hit),
    .o_row   (w_row)
  );

  assign w_next_idx  = r_idx + 7'd1;
  assign w_hits_inc  = r_hits + 7'd1;
  assign w_last      = (r_idx == c_last_idx);
  assign w_cap       = (w_hits_inc == c_hit_cap);
  assign w_handshake = (r_state == S_EMIT) && r_valid && out_ready_i;

  // A line start overrides whatever the scan was doing this cycle.
  assign w_to_done = line_start_i ? !sprites_en_i
                   : (((r_state == S_CHK) && !w_hit && w_last) ||
                      (w_handshake && (w_cap || w_last)));

  always_comb begin
    rd_en_o   = 1'b0;
    rd_addr_o = 8'd0;
    if (line_start_i) begin
      if (sprites_en_i) begin
        rd_en_o   = 1'b1;
        rd_addr_o = 8'd1;
      end
    end else begin
      case (r_state)
        S_CHK: begin
          if (w_hit) begin
            rd_en_o   = 1'b1;
            rd_addr_o = {r_idx, 1'b0};
          end else if (!w_last) begin
            rd_en_o   = 1'b1;
            rd_addr_o = {w_next_idx, 1'b1};
          end
        end
        S_EMIT: begin
          if (w_handshake && !w_cap && !w_last) begin
            rd_en_o   = 1'b1;
            rd_addr_o = {w_next_idx, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_idx   <= '0;
      r_hits  <= '0;
      r_attr  <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_to_done;
      if (line_start_i) begin
        r_line  <= line_idx_i;
        r_idx   <= '0;
        r_hits  <= '0;
        r_valid <= 1'b0;
        r_state <= sprites_en_i ? S_CHK : S_DONE;
      end else begin
        case (r_state)
          S_CHK: begin
            if (w_hit) begin
              r_attr[63:32] <= rd_data_i;
              r_row         <= w_row;
              r_state       <= S_W0;
            end else if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx <= w_next_idx;
            end
          end
          S_W0: begin
            r_attr[31:0] <= rd_data_i;
            r_valid      <= 1'b1;
            r_state      <= S_EMIT;
          end
          S_EMIT: begin
            if (w_handshake) begin
              r_valid <= 1'b0;
              r_hits  <= w_hits_inc;
              if (w_cap || w_last) begin
                r_state <= S_DONE;
              end else begin
                r_idx   <= w_next_idx;
                r_state <= S_CHK;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SPRITE_SCAN_STATS_EN
  logic [6:0] r_hit_count;
  logic       r_overflow;

  // Overflow means the cap cut the scan short with sprites still untested.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hit_count <= '0;
      r_overflow  <= 1'b0;
    end else if (w_to_done) begin
      r_hit_count <= line_start_i ? 7'd0 : (w_handshake ? w_hits_inc : r_hits);
      r_overflow  <= !line_start_i && w_handshake && w_cap && !w_last;
    end
  end

  assign hit_count_o = r_hit_count;
  assign overflow_o  = r_overflow;
`endif

  assign out_valid_o = r_valid;
  assign out_idx_o   = r_idx;
  assign out_attr_o  = r_attr;
  assign out_row_o   = r_row;
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sprite_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Module  : tb_sprite_scan_ctrl
// Purpose : Self-checking bench for sprite_scan_ctrl against a list-based model.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sprite_scan_ctrl;

  localparam int NUM  = 128;
  localparam int MAXH = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        line_start_i = 1'b0;
  logic [9:0]  line_idx_i = '0;
  logic        sprites_en_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_data_i;
  logic        out_valid_o;
  logic [6:0]  out_idx_o;
  logic [63:0] out_attr_o;
  logic [5:0]  out_row_o;
  logic        busy_o;
  logic        done_o;
`ifdef SPRITE_SCAN_STATS_EN
  logic [6:0]  hit_count_o;
  logic        overflow_o;
`endif

  typedef struct packed {
    logic [6:0]  idx;
    logic [63:0] attr;
    logic [5:0]  row;
  } rec_t;

  logic [31:0] mem [256];
  rec_t        exp_q[$];
  rec_t        act_q[$];
  logic [7:0]  rd_q[$];
  bit          exp_ovf;
  int          done_cyc;
  int          first_valid_cyc;
  int          stall_cnt;
  int          stall_bad;
  int          n_checks = 0;
  int          n_fail = 0;

  sprite_scan_ctrl dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .line_start_i (line_start_i),
    .line_idx_i   (line_idx_i),
    .sprites_en_i (sprites_en_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_idx_o    (out_idx_o),
    .out_attr_o   (out_attr_o),
    .out_row_o    (out_row_o),
    .busy_o       (busy_o),
`ifdef SPRITE_SCAN_STATS_EN
    .hit_count_o  (hit_count_o),
    .overflow_o   (overflow_o),
`endif
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_w1(input int y, input int z, input int flip, input int size);
    logic [31:0] w;
    w        = $urandom;
    w[9:0]   = 10'(y);
    w[17]    = 1'(flip);
    w[19:18] = 2'(z);
    w[23:22] = 2'(size);
    return w;
  endfunction

  // Reference: walk sprites in priority order, keep the first MAXH vertical hits.
  task automatic build_expected(input logic [9:0] line, input bit en);
    logic [31:0] w1;
    int y, h, dy;
    rec_t r;
    exp_q.delete();
    exp_ovf = 0;
    if (en) begin
      for (int n = 0; n < NUM; n++) begin
        w1 = mem[2*n+1];
        y  = int'(w1[9:0]);
        h  = 8 << w1[23:22];
        dy = (int'(line) - y + 1024) % 1024;
        if (w1[19:18] != 2'b00 && dy < h) begin
          r.idx  = 7'(n);
          r.attr = {w1, mem[2*n]};
          r.row  = 6'(w1[17] ? (h - 1 - dy) : dy);
          exp_q.push_back(r);
          if (exp_q.size() == MAXH) break;
        end
      end
      if (exp_q.size() == MAXH && int'(exp_q[MAXH-1].idx) != NUM - 1) exp_ovf = 1;
    end
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stall 10 cycles on first record, 3 low until abort
  task automatic run_scan(input string tag, input logic [9:0] line, input bit en,
                          input int ready_mode, input int abort_at, input logic [9:0] line2);
    rec_t snap;
    int base;
    act_q.delete();
    rd_q.delete();
    done_cyc = -1;
    first_valid_cyc = -1;
    stall_cnt = 0;
    stall_bad = 0;
    base = 0;
    build_expected(line, en);
    @(posedge clk_i); #1;
    line_start_i = 1'b1;
    line_idx_i   = line;
    sprites_en_i = en;
    out_ready_i  = 1'b0;
    #2;
    if (rd_en_o) rd_q.push_back(rd_addr_o);
    for (int cyc = 1; cyc < 3000 && done_cyc < 0; cyc++) begin
      @(posedge clk_i); #1;
      line_start_i = 1'b0;
      if (cyc == abort_at) begin
        line_start_i = 1'b1;
        line_idx_i   = line2;
        base         = cyc;
        build_expected(line2, en);
        act_q.delete();
        rd_q.delete();
        first_valid_cyc = -1;
      end
      case (ready_mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid_o && stall_cnt < 10) begin
            out_ready_i = 1'b0;
            if (stall_cnt == 0) snap = '{out_idx_o, out_attr_o, out_row_o};
            else if (snap !== rec_t'({out_idx_o, out_attr_o, out_row_o})) stall_bad++;
            stall_cnt++;
          end else begin
            out_ready_i = 1'b1;
          end
        end
        default: out_ready_i = (cyc > abort_at);
      endcase
      #2;
      if (ready_mode == 2 && !out_ready_i && rd_en_o) stall_bad++;
      if (cyc == abort_at) begin
        check({tag, ".abort_rd"}, {rd_en_o, rd_addr_o}, {1'b1, 8'd1});
        check({tag, ".abort_valid_pre"}, out_valid_o, 1'b1);
      end
      if (abort_at > 0 && cyc == abort_at + 1)
        check({tag, ".abort_valid_drop"}, out_valid_o, 1'b0);
      if (rd_en_o) rd_q.push_back(rd_addr_o);
      if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc - base;
      if (out_valid_o && out_ready_i) act_q.push_back('{out_idx_o, out_attr_o, out_row_o});
      if (done_o) done_cyc = cyc - base;
    end
    check({tag, ".done_seen"}, (done_cyc >= 0), 1'b1);
    check({tag, ".rec_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s.rec%0d", tag, i), act_q[i], exp_q[i]);
    @(posedge clk_i); #3;
    check({tag, ".back_idle"}, {done_o, busy_o}, 2'b00);
`ifdef SPRITE_SCAN_STATS_EN
    check({tag, ".hit_count"}, hit_count_o, 7'(exp_q.size()));
    check({tag, ".overflow"}, overflow_o, exp_ovf);
`endif
  endtask

  initial begin
    logic [9:0] rline;
    int yoff;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #3;
    check("reset_outputs", {out_valid_o, busy_o, done_o, rd_en_o}, 4'b0000);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // One 16-high sprite at Y=100
    mem[0] = 32'h0123_4567;
    mem[1] = mk_w1(100, 3, 0, 1);
    run_scan("t1", 10'd107, 1'b1, 0, 0, 10'd0);
    check("t1.row", act_q.size() > 0 ? act_q[0].row : 6'h3f, 6'd7);
    check("t1.rd_seq", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]}, {8'd1, 8'd0, 8'd3, 8'd5});
    check("t1.first_valid", first_valid_cyc, 3);
    check("t1.done_cycle", done_cyc, 131);

    // Vertical flip and edges of the sprite band
    mem[1] = mk_w1(100, 3, 1, 1);
    run_scan("t2a", 10'd107, 1'b1, 0, 0, 10'd0);
    check("t2a.row", act_q.size() > 0 ? act_q[0].row : 6'h3f, 6'd8);
    run_scan("t2b", 10'd116, 1'b1, 0, 0, 10'd0);
    check("t2b.all_miss_cycles", done_cyc, NUM + 1);
    run_scan("t2c", 10'd99, 1'b1, 0, 0, 10'd0);

    // Cap at MAXH with 20 hitting sprites
    for (int n = 0; n < 20; n++) begin
      mem[2*n]   = $urandom;
      mem[2*n+1] = mk_w1(200, 1, 0, 0);
    end
    run_scan("t3", 10'd203, 1'b1, 0, 0, 10'd0);
    check("t3.count16", act_q.size(), 16);

    // Renderer stall
    run_scan("t4", 10'd205, 1'b1, 2, 0, 10'd0);
    check("t4.stall_stable", {stall_cnt, stall_bad}, {32'd10, 32'd0});

    // Abort while a record is pending
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[80] = $urandom;
    mem[81] = mk_w1(300, 2, 0, 0);
    mem[10] = $urandom;
    mem[11] = mk_w1(498, 1, 0, 0);
    run_scan("t5", 10'd300, 1'b1, 3, 46, 10'd500);
    check("t5.restart_done_cycle", done_cyc, 131);

    // Wrap-around at the bottom of the frame, then disabled sprites
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[7] = mk_w1(1020, 1, 0, 0);
    run_scan("t6a", 10'd3, 1'b1, 0, 0, 10'd0);
    check("t6a.row", act_q.size() > 0 ? act_q[0].row : 6'h3f, 6'd7);
    run_scan("t6b", 10'd3, 1'b0, 0, 0, 10'd0);
    check("t6b.done_cycle", done_cyc, 1);
    check("t6b.no_reads", rd_q.size(), 0);

    // Randomised sprite tables with a random renderer
    for (int t = 0; t < 6; t++) begin
      rline = 10'($urandom);
      for (int n = 0; n < NUM; n++) begin
        yoff = int'($urandom_range(0, 90));
        mem[2*n]   = $urandom;
        mem[2*n+1] = mk_w1((int'(rline) - yoff + 1024) % 1024, int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
      run_scan($sformatf("rnd%0d", t), rline, 1'b1, 1, 0, 10'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
